// File: rtl/decode_pkg.sv
// Shared decode definitions: control-bundle packing, alu_op encodings and
// the opcode constants used by the decode and execute stages.
//   CTRL_W          width of the packed control bundle
//   CTRL_*          bit index of each field inside the bundle (MSB first:
//                   branch, reg_write, mem_read, mem_to_reg, alu_op[1:0],
//                   mem_write, alu_src, is_imm)
//   alu_op_e        2-bit ALU operation class
//   OP_*            7-bit base opcodes
package decode_pkg;

    localparam int unsigned CTRL_W = 9;

    localparam int unsigned CTRL_BRANCH     = 8;
    localparam int unsigned CTRL_REG_WRITE  = 7;
    localparam int unsigned CTRL_MEM_READ   = 6;
    localparam int unsigned CTRL_MEM_TO_REG = 5;
    localparam int unsigned CTRL_ALU_OP_HI  = 4;
    localparam int unsigned CTRL_ALU_OP_LO  = 3;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_ALU_SRC    = 1;
    localparam int unsigned CTRL_IS_IMM     = 0;

    typedef enum logic [1:0] {
        ALU_OP_MEM    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_R      = 2'b10,
        ALU_OP_JUMP   = 2'b11
    } alu_op_e;

    // Same packing as id_ctrl/ex_ctrl, for code that prefers named fields.
    typedef struct packed {
        logic    branch;
        logic    reg_write;
        logic    mem_read;
        logic    mem_to_reg;
        alu_op_e alu_op;
        logic    mem_write;
        logic    alu_src;
        logic    is_imm;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/load_use_hazard.sv
// Combinational load-use hazard detector.
// Raises hazard when the instruction in EX is a load whose destination
// (non-zero) is read by the valid instruction in decode.
//   id_valid, id_rs1, id_rs2       decode instruction and its sources
//   id_alu_src, id_mem_write       decode control bits deciding rs2 usage
//   ex_valid, ex_mem_read, ex_rd   instruction currently in EX
//   hazard                         stall decode and inject a bubble
module load_use_hazard
    import decode_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  id_valid,
    input  logic                  id_alu_src,
    input  logic                  id_mem_write,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    logic rs2_used;
    logic rd_nonzero;
    logic src_match;

    always_comb begin
        // Stores read rs2 as data even though alu_src selects the immediate.
        rs2_used   = ~id_alu_src | id_mem_write;
        rd_nonzero = (ex_rd != '0);
        src_match  = (ex_rd == id_rs1) | (rs2_used & (ex_rd == id_rs2));
        hazard     = id_valid & ex_valid & ex_mem_read & rd_nonzero & src_match;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush, downstream hold and
// saturating perf counters.
//   clk, rst_n                     clock, async active-low reset
//   id_*                           decoded instruction from decode
//   flush                          redirect; kills EX contents (highest priority)
//   ex_hold                        downstream stall; EX register holds
//   id_stall_o                     decode/fetch must hold (combinational)
//   ex_*                           registered instruction presented to execute
//   bubble_count, flush_count      saturating event counters
module id_ex_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [2:0]            id_funct3,
    input  logic                  flush,
    input  logic                  ex_hold,
    output logic                  id_stall_o,
    output logic                  ex_valid,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [2:0]            ex_funct3,
    output logic [CNT_W-1:0]      bubble_count,
    output logic [CNT_W-1:0]      flush_count
);

    logic hazard;

    load_use_hazard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_valid     (id_valid),
        .id_alu_src   (id_ctrl[CTRL_ALU_SRC]),
        .id_mem_write (id_ctrl[CTRL_MEM_WRITE]),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_ctrl[CTRL_MEM_READ]),
        .ex_rd        (ex_rd),
        .hazard       (hazard)
    );

    // A flush discards whatever decode holds, so there is nothing to stall.
    assign id_stall_o = (hazard | ex_hold) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_ctrl      <= '0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_funct3    <= '0;
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (flush || (!ex_hold && hazard)) begin
                // Flush and bubble both leave an all-zero, invalid EX slot.
                ex_valid    <= 1'b0;
                ex_ctrl     <= '0;
                ex_pc       <= '0;
                ex_rs1_data <= '0;
                ex_rs2_data <= '0;
                ex_imm      <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_rd       <= '0;
                ex_funct3   <= '0;
            end else if (!ex_hold) begin
                ex_valid    <= id_valid;
                ex_ctrl     <= id_valid ? id_ctrl : '0;
                ex_pc       <= id_pc;
                ex_rs1_data <= id_rs1_data;
                ex_rs2_data <= id_rs2_data;
                ex_imm      <= id_imm;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rd       <= id_rd;
                ex_funct3   <= id_funct3;
            end

            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
            if (!flush && !ex_hold && hazard && (bubble_count != '1)) begin
                bubble_count <= bubble_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the EX slot.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    // Control bundles: {branch, reg_write, mem_read, mem_to_reg, alu_op, mem_write, alu_src, is_imm}
    localparam logic [8:0] C_ADD  = 9'b0_1_0_0_10_0_0_0;
    localparam logic [8:0] C_LW   = 9'b0_1_1_1_00_0_1_1;
    localparam logic [8:0] C_ADDI = 9'b0_1_0_0_10_0_1_1;
    localparam logic [8:0] C_SW   = 9'b0_0_0_0_00_1_1_1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            id_valid = 1'b0;
    logic [8:0]      id_ctrl = '0;
    logic [XLEN-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [RW-1:0]   id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [2:0]      id_funct3 = '0;
    logic            flush = 1'b0, ex_hold = 1'b0;
    logic            id_stall_o, ex_valid;
    logic [8:0]      ex_ctrl;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [RW-1:0]   ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;
    logic [CW-1:0]   bubble_count, flush_count;

    int checks = 0;
    int failures = 0;

    // Reference model of the EX slot and counters.
    bit              m_valid;
    logic [8:0]      m_ctrl;
    logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [RW-1:0]   m_rs1, m_rs2, m_rd;
    logic [2:0]      m_f3;
    int              m_bub, m_fl;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_pc        (id_pc),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_funct3    (id_funct3),
        .flush        (flush),
        .ex_hold      (ex_hold),
        .id_stall_o   (id_stall_o),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .ex_pc        (ex_pc),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_funct3    (ex_funct3),
        .bubble_count (bubble_count),
        .flush_count  (flush_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0;
    endtask

    task automatic chk_all();
        chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
        chk("ex_ctrl", {55'd0, ex_ctrl}, {55'd0, m_ctrl});
        chk("ex_pc", {32'd0, ex_pc}, {32'd0, m_pc});
        chk("ex_rs1_data", {32'd0, ex_rs1_data}, {32'd0, m_rs1d});
        chk("ex_rs2_data", {32'd0, ex_rs2_data}, {32'd0, m_rs2d});
        chk("ex_imm", {32'd0, ex_imm}, {32'd0, m_imm});
        chk("ex_idx", {49'd0, ex_rs1, ex_rs2, ex_rd}, {49'd0, m_rs1, m_rs2, m_rd});
        chk("ex_funct3", {61'd0, ex_funct3}, {61'd0, m_f3});
        chk("bubble_count", 64'(bubble_count), 64'(m_bub));
        chk("flush_count", 64'(flush_count), 64'(m_fl));
    endtask

    // Present the current id_* inputs for one clock, checking the stall
    // before the edge and the whole EX slot after it.
    task automatic tick(input bit do_chk);
        bit rs2u, haz, stall;
        #1;
        rs2u  = !id_ctrl[1] || id_ctrl[2];
        haz   = id_valid && m_valid && m_ctrl[6] && (m_rd != 0) &&
                ((m_rd == id_rs1) || (rs2u && (m_rd == id_rs2)));
        stall = (haz || ex_hold) && !flush;
        if (do_chk) chk("id_stall_o", {63'd0, id_stall_o}, {63'd0, stall});
        if (flush) begin
            model_clear();
            if (m_fl < CMAX) m_fl++;
        end else if (ex_hold) begin
            // slot holds
        end else if (haz) begin
            model_clear();
            if (m_bub < CMAX) m_bub++;
        end else begin
            m_valid = id_valid; m_ctrl = id_valid ? id_ctrl : 9'd0;
            m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_f3 = id_funct3;
        end
        @(posedge clk);
        #1;
        if (do_chk) chk_all();
    endtask

    task automatic set_id(input bit v, input logic [8:0] c, input logic [RW-1:0] s1,
                          input logic [RW-1:0] s2, input logic [RW-1:0] d,
                          input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
        id_valid = v; id_ctrl = c; id_rs1 = s1; id_rs2 = s2; id_rd = d;
        id_rs1_data = d1; id_rs2_data = d2;
        id_pc = $urandom; id_imm = $urandom; id_funct3 = 3'($urandom);
    endtask

    initial begin
        model_clear();
        m_bub = 0;
        m_fl  = 0;

        // Reset state.
        @(posedge clk);
        #1;
        chk_all();
        rst_n = 1'b1;

        // Pass-through of an R-type.
        set_id(1, C_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        tick(1);
        chk("pt_rs1_data", 64'(ex_rs1_data), 64'd5);
        chk("pt_rs2_data", 64'(ex_rs2_data), 64'd7);
        chk("pt_ctrl", 64'(ex_ctrl), 64'(C_ADD));

        // Asynchronous reset between edges.
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        chk_all();
        chk("rst_valid", {63'd0, ex_valid}, 64'd0);
        #1 rst_n = 1'b1;

        // Load-use: one bubble, then the dependent add is captured.
        set_id(1, C_LW, 5'd1, 5'd9, 5'd5, 32'h100, 32'h0);
        tick(1);
        set_id(1, C_ADD, 5'd5, 5'd2, 5'd4, 32'h11, 32'h22);
        tick(1);
        chk("lu_bubble", 64'(bubble_count), 64'd1);
        chk("lu_ex_ctrl", 64'(ex_ctrl), 64'd0);
        tick(1);
        chk("lu_captured_rd", 64'(ex_rd), 64'd4);

        // lw x0 -> add x0: no stall.
        set_id(1, C_LW, 5'd1, 5'd0, 5'd0, 32'h1, 32'h2);
        tick(1);
        set_id(1, C_ADD, 5'd0, 5'd3, 5'd7, 32'h3, 32'h4);
        tick(1);
        // lw x6 -> addi with rs2 field 6: no stall.
        set_id(1, C_LW, 5'd1, 5'd0, 5'd6, 32'h5, 32'h6);
        tick(1);
        set_id(1, C_ADDI, 5'd1, 5'd6, 5'd8, 32'h7, 32'h8);
        tick(1);
        // lw x6 -> sw rs2=x6: stall.
        set_id(1, C_LW, 5'd1, 5'd0, 5'd6, 32'h9, 32'ha);
        tick(1);
        set_id(1, C_SW, 5'd2, 5'd6, 5'd0, 32'hb, 32'hc);
        #1;
        chk("sw_stall", {63'd0, id_stall_o}, 64'd1);
        tick(1);
        tick(1);

        // Hold for three cycles with changing decode inputs.
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 9'($urandom) & ~9'h040, 5'($urandom), 5'($urandom), 5'($urandom),
                   $urandom, $urandom);
            tick(1);
        end
        ex_hold = 1'b0;

        // Pending hazard under hold: no bubble until hold drops.
        set_id(1, C_LW, 5'd1, 5'd0, 5'd7, 32'h1, 32'h2);
        tick(1);
        set_id(1, C_ADD, 5'd7, 5'd1, 5'd9, 32'h3, 32'h4);
        ex_hold = 1'b1;
        tick(1);
        tick(1);
        ex_hold = 1'b0;
        tick(1);
        tick(1);

        // Flush + hold + hazard together: flush wins.
        set_id(1, C_LW, 5'd1, 5'd0, 5'd8, 32'h1, 32'h2);
        tick(1);
        set_id(1, C_ADD, 5'd8, 5'd8, 5'd9, 32'h3, 32'h4);
        ex_hold = 1'b1;
        flush   = 1'b1;
        tick(1);
        ex_hold = 1'b0;
        flush   = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 7) != 0, 9'($urandom), 3'($urandom), 3'($urandom),
                   3'($urandom), $urandom, $urandom);
            flush   = ($urandom_range(0, 9) == 0);
            ex_hold = ($urandom_range(0, 5) == 0);
            tick(1);
        end
        ex_hold = 1'b0;

        // Flush counter saturation.
        flush = 1'b1;
        for (int i = 0; i < CMAX + 3; i++) tick(0);
        chk("flush_sat", 64'(flush_count), 64'(CMAX));
        tick(1);
        flush = 1'b0;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Pipeline register between decode and execute. It latches the decoded control bundle, operands and register addresses each cycle. It also detects load-use hazards against the instruction currently in EX, stalls decode and injects a bubble. It supports a branch-resolution flush, a downstream hold, and saturating perf counters for bubbles and flushes.

Parameters:
XLEN, 32, operand/PC/immediate width
REG_ADDR_W, 5, register index width
CNT_W, 16, perf counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode holds a valid instruction
id_ctrl  in  9  {branch, reg_write, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, is_imm}, MSB first
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  rs1 value from register file
id_rs2_data  in  XLEN  rs2 value from register file
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  REG_ADDR_W  rs1 index
id_rs2  in  REG_ADDR_W  rs2 index
id_rd  in  REG_ADDR_W  rd index
id_funct3  in  3  funct3 forwarded to ALU control
flush  in  1  branch/jump redirect; kills EX contents
ex_hold  in  1  downstream stall; EX register must hold
id_stall_o  out  1  decode/fetch must hold current instruction
ex_valid  out  1  EX holds a valid instruction
ex_ctrl  out  9  latched control bundle, same packing as id_ctrl
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  latched datapath values
ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W each  latched indices
ex_funct3  out  3  latched funct3
bubble_count  out  CNT_W  load-use bubbles inserted, saturating
flush_count  out  CNT_W  cycles with flush asserted, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_* outputs 0, ex_valid 0, both counters 0. Reset asserted mid-operation discards EX contents immediately; no partial state survives.
- rs2 usage: rs2_used = ~alu_src | mem_write, taken from id_ctrl. rs1 is treated as used for every valid instruction.
- Hazard (combinational): hazard = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (rs2_used & ex_rd==id_rs2)).
- id_stall_o = (hazard | ex_hold) & ~flush. This is combinational, with zero-cycle latency to decode.
- Register update priority per rising edge:
  1. flush: ex_valid<=0; all other ex_* <=0.
  2. else ex_hold: every ex_* register holds its value. No bubble is inserted; a hazard stays pending.
  3. else hazard: bubble. ex_valid<=0, ex_ctrl<=0, datapath regs <=0. bubble_count+1.
  4. else: capture all id_* into ex_*; ex_valid<=id_valid. ex_ctrl<=id_valid ? id_ctrl : 0.
- Invariant: ex_valid=0 implies ex_ctrl=0, so reg_write and mem_write are never spuriously asserted.
- Latency: one cycle from id_* to ex_*. A load-use hazard costs exactly one bubble, then the dependent instruction is captured on the following edge. In that cycle the load has left EX, so the hazard is clear.
- Counters: flush_count+1 on each edge with flush=1. Both counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous flush, ex_hold and hazard: flush wins, id_stall_o=0, bubble_count unchanged.

Decomposition:
- Shared package (decode_pkg): CTRL_W=9, bit-index constants for each id_ctrl field, and alu_op encodings ALU_OP_MEM=00, ALU_OP_BRANCH=01, ALU_OP_R=10, ALU_OP_JUMP=11.
- Shared package also holds opcode constants: OP_R=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_JALR=1100111.
- Sub-module load_use_hazard: purely combinational; computes hazard from the ex_* and id_* fields above. The register, priority logic and counters stay in id_ex_stage.

Test Plan:
- Reset mid-run: load a valid R-type, then pulse rst_n=0 between edges -> all ex_* and counters read 0 immediately, before the next edge.
- Pass-through: id_valid=1, id_ctrl=0_1_0_0_10_0_0_0, rs1_data=5, rs2_data=7, rd=3 -> next edge: ex_valid=1, identical ctrl, ex_rs1_data=5, ex_rs2_data=7, ex_rd=3, id_stall_o=0.
- Load-use: EX holds lw rd=x5 (mem_read=1); ID holds add rs1=x5 -> id_stall_o=1. Next edge: ex_valid=0, ex_ctrl=0, bubble_count=1. Following edge: add captured, id_stall_o=0.
- No false hazard:
  - lw rd=x0 followed by add rs1=x0 -> no stall.
  - lw rd=x6 followed by addi (alu_src=1) with rs2 field=6 -> no stall.
  - lw rd=x6 followed by sw rs2=x6 -> stall.
- Hold: ex_hold=1 for 3 cycles with new id_* values -> ex_* unchanged and id_stall_o=1 throughout. With a pending hazard, bubble_count stays unchanged while ex_hold=1.
- Flush priority: flush=1, ex_hold=1 and a hazard in the same cycle -> id_stall_o=0; next edge ex_valid=0, flush_count+1, bubble_count unchanged. Also drive flush for 2^CNT_W+2 cycles -> flush_count holds at the maximum value.
